// File: rtl/mc_core.sv
// mc_core: multi-cycle RV32I-subset core.
// FETCH/DECODE/EXEC/MEM/WB FSM with req/valid memory handshakes.
module mc_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NREGS    = 32
) (
  input  logic        clock,
  input  logic        resetn,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_valid,
  output logic        retire,
  output logic        halted,
  output logic [31:0] pc
);
  localparam int AW = $clog2(NREGS);
  localparam logic [5:0] NR = 6'(NREGS);

  typedef enum logic [2:0] {
    FETCH, DECODE, EXEC, MEM, WB, HALT
  } state_e;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR,
    OP_XOR, OP_SLT, OP_ADDI, OP_LW,
    OP_SW, OP_BEQ, OP_BNE, OP_JAL
  } op_e;

  state_e      state_q;
  op_e         op_q;
  op_e         dec_op;
  logic [31:0] ir_q;
  logic [31:0] pc_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] imm_q;
  logic [31:0] res_q;
  logic [4:0]  rd_q;
  logic [31:0] rf_q [NREGS];
  logic        imem_req_q;
  logic        dmem_req_q;
  logic        dmem_we_q;
  logic [31:0] dmem_addr_q;
  logic [31:0] dmem_wdata_q;
  logic        retire_q;
  logic        halted_q;

  assign imem_req   = imem_req_q;
  assign imem_addr  = pc_q;
  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign retire     = retire_q;
  assign halted     = halted_q;
  assign pc         = pc_q;

  logic [6:0]  opc;
  logic [6:0]  f7;
  logic [2:0]  f3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic        is_r;
  logic        f7z;
  logic        f7s;
  logic        dec_ok;
  logic        use1;
  logic        use2;
  logic        used;
  logic        bad_idx;
  logic [31:0] dec_imm;

  assign opc  = ir_q[6:0];
  assign rd   = ir_q[11:7];
  assign f3   = ir_q[14:12];
  assign rs1  = ir_q[19:15];
  assign rs2  = ir_q[24:20];
  assign f7   = ir_q[31:25];
  assign is_r = opc == 7'b0110011;
  assign f7z  = f7 == 7'b0000000;
  assign f7s  = f7 == 7'b0100000;

  always_comb begin
    dec_op = OP_ADD;
    dec_ok = 1'b1;
    unique case (1'b1)
      is_r && f7z && f3 == 3'd0: dec_op = OP_ADD;
      is_r && f7s && f3 == 3'd0: dec_op = OP_SUB;
      is_r && f7z && f3 == 3'd7: dec_op = OP_AND;
      is_r && f7z && f3 == 3'd6: dec_op = OP_OR;
      is_r && f7z && f3 == 3'd4: dec_op = OP_XOR;
      is_r && f7z && f3 == 3'd2: dec_op = OP_SLT;
      opc == 7'b0010011 && f3 == 3'd0:
        dec_op = OP_ADDI;
      opc == 7'b0000011 && f3 == 3'd2:
        dec_op = OP_LW;
      opc == 7'b0100011 && f3 == 3'd2:
        dec_op = OP_SW;
      opc == 7'b1100011 && f3 == 3'd0:
        dec_op = OP_BEQ;
      opc == 7'b1100011 && f3 == 3'd1:
        dec_op = OP_BNE;
      opc == 7'b1101111:
        dec_op = OP_JAL;
      default: dec_ok = 1'b0;
    endcase
  end

  // operand usage decides which index fields must be in range
  always_comb begin
    use1 = dec_op != OP_JAL;
    use2 = is_r || dec_op == OP_SW ||
           dec_op == OP_BEQ || dec_op == OP_BNE;
    used = is_r || dec_op == OP_ADDI ||
           dec_op == OP_LW || dec_op == OP_JAL;
    bad_idx = (use1 && {1'b0, rs1} >= NR) ||
              (use2 && {1'b0, rs2} >= NR) ||
              (used && {1'b0, rd} >= NR);
  end

  always_comb begin
    dec_imm = {{20{ir_q[31]}}, ir_q[31:20]};
    case (dec_op)
      OP_SW:
        dec_imm = {{20{ir_q[31]}}, ir_q[31:25],
                   ir_q[11:7]};
      OP_BEQ, OP_BNE:
        dec_imm = {{19{ir_q[31]}}, ir_q[31], ir_q[7],
                   ir_q[30:25], ir_q[11:8], 1'b0};
      OP_JAL:
        dec_imm = {{11{ir_q[31]}}, ir_q[31],
                   ir_q[19:12], ir_q[20],
                   ir_q[30:21], 1'b0};
      default: ;
    endcase
  end

  logic [31:0] alu;
  logic [31:0] tgt;
  logic [31:0] pc4;
  logic        is_mem;
  logic        is_br;
  logic        take;

  assign tgt    = pc_q + imm_q;
  assign pc4    = pc_q + 32'd4;
  assign is_mem = op_q == OP_LW || op_q == OP_SW;
  assign is_br  = op_q == OP_BEQ || op_q == OP_BNE ||
                  op_q == OP_JAL;
  assign take   = (op_q == OP_BEQ && a_q == b_q) ||
                  (op_q == OP_BNE && a_q != b_q) ||
                  op_q == OP_JAL;

  always_comb begin
    alu = a_q + b_q;
    case (op_q)
      OP_SUB: alu = a_q - b_q;
      OP_AND: alu = a_q & b_q;
      OP_OR:  alu = a_q | b_q;
      OP_XOR: alu = a_q ^ b_q;
      OP_SLT:
        alu = {31'd0, $signed(a_q) < $signed(b_q)};
      OP_ADDI, OP_LW, OP_SW: alu = a_q + imm_q;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= FETCH;
      op_q         <= OP_ADD;
      pc_q         <= RESET_PC;
      ir_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      imm_q        <= '0;
      res_q        <= '0;
      rd_q         <= '0;
      imem_req_q   <= 1'b0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      retire_q     <= 1'b0;
      halted_q     <= 1'b0;
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else begin
      retire_q <= 1'b0;
      case (state_q)
        FETCH: begin
          if (!imem_req_q) begin
            imem_req_q <= 1'b1;
          end else if (imem_valid) begin
            imem_req_q <= 1'b0;
            ir_q       <= imem_rdata;
            state_q    <= DECODE;
          end
        end
        DECODE: begin
          op_q  <= dec_op;
          a_q   <= rf_q[rs1[AW-1:0]];
          b_q   <= rf_q[rs2[AW-1:0]];
          imm_q <= dec_imm;
          rd_q  <= rd;
          if (!dec_ok || bad_idx) begin
            halted_q <= 1'b1;
            state_q  <= HALT;
          end else begin
            state_q <= EXEC;
          end
        end
        EXEC: begin
          res_q <= alu;
          if (is_mem && alu[1:0] != 2'b00) begin
            halted_q <= 1'b1;
            state_q  <= HALT;
          end else if (is_mem) begin
            dmem_req_q   <= 1'b1;
            dmem_we_q    <= op_q == OP_SW;
            dmem_addr_q  <= alu;
            dmem_wdata_q <= b_q;
            state_q      <= MEM;
          end else if (is_br && take && tgt[1]) begin
            halted_q <= 1'b1;
            state_q  <= HALT;
          end else if (is_br) begin
            if (op_q == OP_JAL && rd_q != 5'd0)
              rf_q[rd_q[AW-1:0]] <= pc4;
            pc_q       <= take ? tgt : pc4;
            retire_q   <= 1'b1;
            imem_req_q <= 1'b1;
            state_q    <= FETCH;
          end else begin
            state_q <= WB;
          end
        end
        MEM: begin
          if (dmem_valid) begin
            dmem_req_q <= 1'b0;
            if (dmem_we_q) begin
              pc_q       <= pc4;
              retire_q   <= 1'b1;
              imem_req_q <= 1'b1;
              state_q    <= FETCH;
            end else begin
              res_q   <= dmem_rdata;
              state_q <= WB;
            end
          end
        end
        WB: begin
          if (rd_q != 5'd0)
            rf_q[rd_q[AW-1:0]] <= res_q;
          pc_q       <= pc4;
          retire_q   <= 1'b1;
          imem_req_q <= 1'b1;
          state_q    <= FETCH;
        end
        default: begin
          imem_req_q <= 1'b0;
          dmem_req_q <= 1'b0;
          halted_q   <= 1'b1;
          state_q    <= HALT;
        end
      endcase
    end
  end
endmodule

// File: doc/mc_core.md
MC_CORE -- requirements
Module: mc_core

Interface
REQ-001 RESET_PC, 32'h0000_0000, address of first instruction fetch after reset.
REQ-002 NREGS, 32, architectural register count; legal values 16 (RV32E) or 32.
REQ-003 clock  in  1  rising-edge clock; all state updates on posedge.
REQ-004 resetn  in  1  reset, asynchronous, active-low.
REQ-005 imem_req  out  1  instruction fetch request.
REQ-006 imem_addr  out  32  fetch address, equals pc.
REQ-007 imem_rdata  in  32  fetched instruction word.
REQ-008 imem_valid  in  1  imem_rdata valid; completes fetch.
REQ-009 dmem_req  out  1  data access request.
REQ-010 dmem_we  out  1  1 = store, 0 = load.
REQ-011 dmem_addr  out  32  word-aligned data address.
REQ-012 dmem_wdata  out  32  store data.
REQ-013 dmem_rdata  in  32  load data.
REQ-014 dmem_valid  in  1  data access complete (load data valid / store accepted).
REQ-015 retire  out  1  one-cycle pulse per completed instruction.
REQ-016 halted  out  1  sticky; core stopped on illegal or misaligned condition.
REQ-017 pc  out  32  current instruction address.

Function
REQ-018 FSM states FETCH, DECODE, EXEC, MEM, WB, HALT; one state per cycle except FETCH/MEM, which wait for valid.
REQ-019 Supported: ADD SUB AND OR XOR SLT (R), ADDI (I), LW, SW, BEQ, BNE, JAL; any other opcode/funct -> HALT.
REQ-020 rs1/rs2/rd index >= NREGS -> HALT; pc, registers, memory unchanged; no retire.
REQ-021 x0 reads 0; writes to x0 discarded.
REQ-022 Handshake: req asserted with addr/we/wdata stable until the cycle valid=1 is sampled; req deasserts the following cycle; valid while req=0 ignored.
REQ-023 FETCH: imem_req=1; on imem_valid latch instruction -> DECODE.
REQ-024 DECODE: read rs1/rs2, sign-extend I/S/B/J immediates -> EXEC.
REQ-025 EXEC: R/ADDI -> WB; LW/SW compute rs1+imm -> MEM; BEQ/BNE/JAL resolve target, retire here -> FETCH.
REQ-026 LW/SW address bits[1:0] != 0 -> HALT with no dmem_req.
REQ-027 MEM: dmem_req=1; store: on dmem_valid retire -> FETCH; load: on dmem_valid latch data -> WB.
REQ-028 WB: write rd, pc <= pc+4, retire=1 -> FETCH.
REQ-029 Arithmetic 32-bit modulo 2^32; SLT signed; no overflow trap.
REQ-030 Branch taken: pc <= pc+immB; JAL: rd <= pc+4, pc <= pc+immJ; target[1] != 0 -> HALT, no write.
REQ-031 Zero-wait latency (valid same cycle as req): ALU/ADDI 4 cycles, LW 5, SW 4, branch/JAL 3.
REQ-032 HALT: halted=1, all req=0, retire=0; exit only by reset.
REQ-033 pc wraps 32'hFFFF_FFFC+4 -> 32'h0000_0000.

Reset
REQ-034 resetn=0 asynchronously: state FETCH, pc=RESET_PC, all registers 0, imem_req/dmem_req/dmem_we/retire/halted 0, dmem_addr/dmem_wdata 0.
REQ-035 Reset mid-handshake aborts the access; late valid after release is ignored unless a new req is issued.
REQ-036 First imem_req asserts in the first cycle after resetn deasserts.

Verification
REQ-037 ADDI x1,x0,5; ADDI x2,x0,-3; ADD x3,x1,x2; SUB x4,x2,x1 -> x3=2, x4=32'hFFFF_FFF8, 4 retire pulses, 16 cycles at zero wait.
REQ-038 SW x3,8(x0) then LW x5,8(x0) with dmem_valid delayed 3 cycles -> dmem_addr=8, dmem_wdata=2, req held 4 cycles, x5=2.
REQ-039 BNE x1,x0,+8 with x1=5 -> pc advances by 8; BEQ same operands -> pc+4; JAL x1,-4 -> x1=pc+4.
REQ-040 Opcode 7'b0000000, LW addr 0x6, ADD x20 with NREGS=16 -> halted=1, no retire, no dmem_req, registers unchanged.
REQ-041 resetn low during MEM with dmem_req=1 -> req drops same cycle, pc=RESET_PC; stale dmem_valid after release has no effect.
REQ-042 ADDI x0,x0,7 then ADD x6,x0,x0 -> x6=0.
